// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit and its memory.
// The fetch unit uses the master view; the memory model uses the slave view.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26
);
  logic                  MEM_REQ;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic                  MEM_ACK;
  logic [DATA_WIDTH-1:0] MEM_RDATA;

  modport master (
    output MEM_REQ,
    output MEM_ADDR,
    input  MEM_ACK,
    input  MEM_RDATA
  );

  modport slave (
    input  MEM_REQ,
    input  MEM_ADDR,
    output MEM_ACK,
    output MEM_RDATA
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, issues one REQ/ACK memory read per
// fetch with a bounded wait, and selects the next PC from four sources.
// ADDR_WIDTH must satisfy 16 < ADDR_WIDTH < DATA_WIDTH; TIMEOUT must be >= 1.
module instr_fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 26,
  parameter logic [31:0] PC_RESET   = 32'h0000_1000,
  parameter int          PC_STEP    = 1,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  PC_LOAD,
  input  logic [1:0]            PC_SRC,
  input  logic [DATA_WIDTH-1:0] REG_TARGET,
  instr_fetch_unit_if.master    mem,
  output logic [DATA_WIDTH-1:0] INSTRUCTION,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PC_PLUS,
  output logic                  BUSY,
  output logic                  IR_VALID,
  output logic                  FETCH_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] PC_RST_VAL = DATA_WIDTH'(PC_RESET);
  localparam logic [DATA_WIDTH-1:0] PC_INC     = DATA_WIDTH'(PC_STEP);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] pc_plus;
  logic [DATA_WIDTH-1:0] branch_off;
  logic [DATA_WIDTH-1:0] pc_sel;

  // Return address and branch offset derived from the current PC and IR.
  always_comb begin
    pc_plus    = pc_q + PC_INC;
    branch_off = {{(DATA_WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  end

  // Next-PC multiplexer; arithmetic wraps silently.
  always_comb begin
    pc_sel = pc_plus;
    case (PC_SRC)
      2'b00:   pc_sel = pc_plus;
      2'b01:   pc_sel = pc_plus + branch_off;
      2'b10:   pc_sel = {pc_plus[DATA_WIDTH-1:ADDR_WIDTH], ir_q[ADDR_WIDTH-1:0]};
      default: pc_sel = REG_TARGET;
    endcase
  end

  // Fetch FSM next-state logic; outputs are computed here and registered so
  // MEM_REQ/BUSY/IR_VALID/FETCH_ERR come straight from flops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    ir_valid_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        // PC moves only while no read is outstanding, so MEM_ADDR stays
        // stable across the whole request. A same-edge START fetches the
        // freshly loaded PC.
        if (PC_LOAD) begin
          pc_d = pc_sel;
        end
        if (START) begin
          state_d = S_REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_REQ: begin
        // ACK is checked before the timeout so a reply in the last allowed
        // cycle is still accepted.
        if (mem.MEM_ACK) begin
          ir_d       = mem.MEM_RDATA;
          state_d    = S_IDLE;
          req_d      = 1'b0;
          ir_valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register; the asynchronous reset drops MEM_REQ without a clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RST_VAL;
      ir_q       <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    mem.MEM_REQ  = req_q;
    mem.MEM_ADDR = pc_q[ADDR_WIDTH-1:0];
    INSTRUCTION  = ir_q;
    PC           = pc_q;
    PC_PLUS      = pc_plus;
    BUSY         = req_q;
    IR_VALID     = ir_valid_q;
    FETCH_ERR    = err_q;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised instruction-fetch stage for the multi-cycle processor: owns PC and IR.
- Issues one memory read per fetch through a REQ/ACK handshake and bounds the wait with a timeout.
- Computes the next PC from four sources (sequential, branch, jump, register).
- Sits between the control unit (START/PC_LOAD/PC_SRC) and instruction memory, and supplies INSTRUCTION to decode and the register file.

Parameters:
- DATA_WIDTH, 32: width of PC, IR, MEM_RDATA and REG_TARGET.
- ADDR_WIDTH, 26: memory address width and jump-field width. Must satisfy 16 < ADDR_WIDTH < DATA_WIDTH.
- PC_RESET, 32'h0000_1000: PC value after reset, truncated to DATA_WIDTH.
- PC_STEP, 1: sequential increment (word-addressed memory).
- TIMEOUT, 15: maximum REQ cycles before error. Must be at least 1.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- START  input  1  request a fetch at the current PC.
- PC_LOAD  input  1  commit the next PC selected by PC_SRC.
- PC_SRC  input  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 register.
- REG_TARGET  input  DATA_WIDTH  register value used when PC_SRC=11.
- MEM_REQ  output  1  memory read request.
- MEM_ADDR  output  ADDR_WIDTH  read address, equal to PC[ADDR_WIDTH-1:0].
- MEM_ACK  input  1  memory read data valid.
- MEM_RDATA  input  DATA_WIDTH  memory read data.
- INSTRUCTION  output  DATA_WIDTH  IR contents.
- PC  output  DATA_WIDTH  current PC.
- PC_PLUS  output  DATA_WIDTH  PC+PC_STEP (combinational; used as the return address).
- BUSY  output  1  high while in REQ.
- IR_VALID  output  1  one-cycle pulse after a successful IR load.
- FETCH_ERR  output  1  timeout flag; sticky until retry or reset.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; PC=PC_RESET; IR=0; timeout counter=0.
  - MEM_REQ=0, BUSY=0, IR_VALID=0, FETCH_ERR=0.
  - Reset during REQ drops MEM_REQ immediately, without waiting for an edge.
- States: IDLE, REQ, ERR.
- IDLE:
  - START=1 -> REQ at the next edge; counter cleared.
  - START=0 -> stay in IDLE.
- REQ:
  - MEM_REQ=1, BUSY=1, MEM_ADDR=PC[ADDR_WIDTH-1:0]; MEM_ADDR is stable for the whole REQ.
  - MEM_ACK=1 at an edge -> IR<=MEM_RDATA, go to IDLE, IR_VALID=1 for exactly the next cycle.
  - MEM_ACK=0 -> counter+1. If counter==TIMEOUT-1 at that edge -> ERR, FETCH_ERR=1.
  - MEM_REQ is therefore asserted for at most TIMEOUT cycles.
  - ACK in the final allowed cycle wins over timeout.
  - START during REQ is ignored.
- ERR:
  - FETCH_ERR=1 and IR is unchanged.
  - START=1 -> REQ at the next edge; FETCH_ERR cleared on that same edge; counter cleared.
- MEM_ACK outside REQ is ignored; IR does not change.
- Minimum latency: START sampled at edge 0, REQ during cycle 1, ACK sampled at edge 1, IR_VALID high in cycle 2.
- PC update:
  - PC_LOAD is honoured only when BUSY=0 (IDLE or ERR); it is ignored in REQ.
  - PC_SRC=00: PC <= PC+PC_STEP.
  - PC_SRC=01: PC <= PC+PC_STEP+sign_extend(IR[15:0]).
  - PC_SRC=10: PC <= {PC_PLUS[DATA_WIDTH-1:ADDR_WIDTH], IR[ADDR_WIDTH-1:0]}.
  - PC_SRC=11: PC <= REG_TARGET.
- Arithmetic is modulo 2^DATA_WIDTH; wrap-around is silent, with no flag.
- START and PC_LOAD in the same IDLE/ERR cycle: PC updates on that edge, and REQ presents the new PC.
- IR_VALID never overlaps BUSY.

Test Plan:
- Reset:
  - Stimulus: RST=0, then release.
  - Required: PC=32'h1000, INSTRUCTION=0, MEM_REQ=0, FETCH_ERR=0.
- Basic fetch:
  - Stimulus: START; memory ACKs after 3 wait cycles with MEM_RDATA=32'h2001_0005.
  - Required: MEM_ADDR=26'h1000 held for 4 REQ cycles; INSTRUCTION=32'h2001_0005; IR_VALID high exactly 1 cycle.
- Sequential and branch:
  - Stimulus: with IR=32'h1000_FFFE, PC_LOAD with PC_SRC=00 from PC=32'h1000.
  - Required: PC=32'h1001.
  - Stimulus: then PC_LOAD with PC_SRC=01.
  - Required: PC=32'h1001+1-2=32'h1000.
- Jump and register:
  - Stimulus: IR[25:0]=26'h000_2040, PC_SRC=10.
  - Required: PC=32'h0000_2040.
  - Stimulus: REG_TARGET=32'hFFFF_FFFF, PC_SRC=11, then PC_SRC=00.
  - Required: PC wraps to 32'h0000_0000.
- Timeout and retry:
  - Stimulus: START with no ACK.
  - Required: MEM_REQ high exactly 15 cycles, then FETCH_ERR=1 and IR unchanged.
  - Stimulus: START again; ACK in cycle 15 of the retry.
  - Required: FETCH_ERR clears on the START edge; IR loads (ACK beats timeout).
- Ignored inputs and reset mid-fetch:
  - Stimulus: PC_LOAD and START pulsed during REQ.
  - Required: PC and state unchanged.
  - Stimulus: assert RST mid-REQ.
  - Required: MEM_REQ falls without waiting for a clock edge; PC=32'h1000.
